// File: rtl/mul_stream_initiator.sv
// Operand-pair initiator and product sink for a valid/ready multiplier wrapper.
// Issues NUM_TX pairs (corner vectors, then LFSR data) and checks every product.
module mul_stream_initiator #(
  parameter int          WIDTH   = 32,
  parameter int          NUM_TX  = 16,
  parameter logic [31:0] SEED_A  = 32'hACE1_1234,
  parameter logic [31:0] SEED_B  = 32'h1357_9BDF,
  parameter int          TIMEOUT = 1024,
  parameter bit          SIGNED  = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   op_a,
  output logic [WIDTH-1:0]   op_b,
  output logic               op_valid,
  input  logic               op_ready,
  input  logic [2*WIDTH-1:0] res_data,
  input  logic               res_valid,
  output logic               res_ready,
  output logic               busy,
  output logic               done,
  output logic [15:0]        err_cnt,
  output logic [15:0]        first_err,
  output logic               timeout
);

  localparam logic [31:0]      SEED_A_NZ = (SEED_A == 32'd0) ? 32'd1 : SEED_A;
  localparam logic [31:0]      SEED_B_NZ = (SEED_B == 32'd0) ? 32'd1 : SEED_B;
  localparam logic [31:0]      LFSR_TAPS = 32'h8020_0003;
  localparam logic [WIDTH-1:0] OPMAX     = '1;
  localparam logic [WIDTH-1:0] OPONE     = WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [15:0]          tx_idx;
  logic [31:0]          tmo_cnt;
  logic [31:0]          lfsr_a, lfsr_b, lfsr_a_nx, lfsr_b_nx;
  logic [2*WIDTH-1:0]   expect_q;
  logic                 start_run, op_fire, res_fire, tmo_hit, last_tx, tmo_limit;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  function automatic logic [2*WIDTH-1:0] pick_ops(input logic [15:0] idx,
                                                  input logic [WIDTH-1:0] la,
                                                  input logic [WIDTH-1:0] lb);
    case (idx)
      16'd0:   return {{WIDTH{1'b0}}, {WIDTH{1'b0}}};
      16'd1:   return {OPMAX, OPMAX};
      16'd2:   return {OPONE, OPMAX};
      16'd3:   return {OPMAX, OPONE};
      default: return {la, lb};
    endcase
  endfunction

  // Product is formed at 2*WIDTH so truncation is exact for both signednesses.
  function automatic logic [2*WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] sa, sb;
    if (SIGNED) begin
      sa = {{WIDTH{a[WIDTH-1]}}, a};
      sb = {{WIDTH{b[WIDTH-1]}}, b};
    end else begin
      sa = {{WIDTH{1'b0}}, a};
      sb = {{WIDTH{1'b0}}, b};
    end
    return sa * sb;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign lfsr_a_nx = lfsr_step(lfsr_a);
  assign lfsr_b_nx = lfsr_step(lfsr_b);
  assign last_tx   = (tx_idx == 16'(NUM_TX - 1));
  assign tmo_limit = (tmo_cnt == 32'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_run = 1'b0;
    op_fire   = 1'b0;
    res_fire  = 1'b0;
    tmo_hit   = 1'b0;
    op_valid  = (state_q == S_ISSUE);
    res_ready = (state_q == S_WAIT);
    busy      = (state_q == S_ISSUE) || (state_q == S_WAIT);
    done      = (state_q == S_DONE);
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          start_run = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (op_ready) begin
          op_fire = 1'b1;
          state_d = S_WAIT;
        end else if (tmo_limit) begin
          tmo_hit = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        if (res_valid) begin
          res_fire = 1'b1;
          state_d  = last_tx ? S_DONE : S_ISSUE;
        end else if (tmo_limit) begin
          tmo_hit = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_idx    <= '0;
      tmo_cnt   <= '0;
      lfsr_a    <= SEED_A_NZ;
      lfsr_b    <= SEED_B_NZ;
      op_a      <= '0;
      op_b      <= '0;
      expect_q  <= '0;
      err_cnt   <= '0;
      first_err <= '0;
      timeout   <= 1'b0;
    end else begin
      if (state_d != state_q) tmo_cnt <= '0;
      else if (busy)          tmo_cnt <= tmo_cnt + 32'd1;

      if (start_run) begin
        tx_idx    <= '0;
        lfsr_a    <= SEED_A_NZ;
        lfsr_b    <= SEED_B_NZ;
        op_a      <= '0;
        op_b      <= '0;
        err_cnt   <= '0;
        first_err <= '0;
        timeout   <= 1'b0;
      end

      // operand acceptance: freeze the reference product for this pair
      if (op_fire) expect_q <= ref_mul(op_a, op_b);

      // product acceptance: score it, then advance to the next pair
      if (res_fire) begin
        if (res_data != expect_q) begin
          err_cnt <= sat_inc(err_cnt);
          if (err_cnt == 16'd0) first_err <= tx_idx;
        end
        if (!last_tx) begin
          tx_idx       <= tx_idx + 16'd1;
          lfsr_a       <= lfsr_a_nx;
          lfsr_b       <= lfsr_b_nx;
          {op_a, op_b} <= pick_ops(tx_idx + 16'd1, lfsr_a_nx[WIDTH-1:0], lfsr_b_nx[WIDTH-1:0]);
        end
      end

      if (tmo_hit) timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mul_stream_initiator.sv
// Bench for mul_stream_initiator: two instances (32-bit unsigned, 8-bit signed)
// driven by randomized multiplier responders and checked against a reference model.
module tb_mul_stream_initiator;

  localparam int          NTX  = 8;
  localparam logic [31:0] SDA  = 32'hACE1_1234;
  localparam logic [31:0] SDB  = 32'h1357_9BDF;

  logic clk, rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  // 32-bit unsigned instance
  logic        start_a, a_op_valid, a_op_ready, a_res_valid, a_res_ready;
  logic        a_busy, a_done, a_timeout;
  logic [31:0] a_op_a, a_op_b;
  logic [63:0] a_res_data;
  logic [15:0] a_err_cnt, a_first_err;

  // 8-bit signed instance
  logic        start_b, b_op_valid, b_op_ready, b_res_valid, b_res_ready;
  logic        b_busy, b_done, b_timeout;
  logic [7:0]  b_op_a, b_op_b;
  logic [15:0] b_res_data;
  logic [15:0] b_err_cnt, b_first_err;

  mul_stream_initiator #(.WIDTH(32), .NUM_TX(NTX), .SEED_A(SDA), .SEED_B(SDB),
                         .TIMEOUT(16), .SIGNED(1'b0)) u_a (
    .clk(clk), .rst(rst), .start(start_a),
    .op_a(a_op_a), .op_b(a_op_b), .op_valid(a_op_valid), .op_ready(a_op_ready),
    .res_data(a_res_data), .res_valid(a_res_valid), .res_ready(a_res_ready),
    .busy(a_busy), .done(a_done), .err_cnt(a_err_cnt), .first_err(a_first_err),
    .timeout(a_timeout));

  mul_stream_initiator #(.WIDTH(8), .NUM_TX(NTX), .SEED_A(SDA), .SEED_B(SDB),
                         .TIMEOUT(16), .SIGNED(1'b1)) u_b (
    .clk(clk), .rst(rst), .start(start_b),
    .op_a(b_op_a), .op_b(b_op_b), .op_valid(b_op_valid), .op_ready(b_op_ready),
    .res_data(b_res_data), .res_valid(b_res_valid), .res_ready(b_res_ready),
    .busy(b_busy), .done(b_done), .err_cnt(b_err_cnt), .first_err(b_first_err),
    .timeout(b_timeout));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] lfsr_after(input logic [31:0] seed, input int n);
    logic [31:0] v;
    v = seed;
    for (int i = 0; i < n; i++) v = v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
    return v;
  endfunction

  function automatic logic [63:0] mul_u32(input logic [31:0] a, input logic [31:0] b);
    return 64'(a) * 64'(b);
  endfunction

  function automatic logic [15:0] mul_s8(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa, sb;
    sa = {{8{a[7]}}, a};
    sb = {{8{b[7]}}, b};
    return 16'(sa * sb);
  endfunction

  logic [31:0] ea_a [NTX];
  logic [31:0] ea_b [NTX];
  logic [7:0]  eb_a [NTX];
  logic [7:0]  eb_b [NTX];

  initial begin
    for (int k = 0; k < NTX; k++) begin
      logic [31:0] la, lb;
      la = lfsr_after(SDA, k);
      lb = lfsr_after(SDB, k);
      case (k)
        0:       begin ea_a[k] = 32'd0;          ea_b[k] = 32'd0;          end
        1:       begin ea_a[k] = 32'hFFFF_FFFF;  ea_b[k] = 32'hFFFF_FFFF;  end
        2:       begin ea_a[k] = 32'd1;          ea_b[k] = 32'hFFFF_FFFF;  end
        3:       begin ea_a[k] = 32'hFFFF_FFFF;  ea_b[k] = 32'd1;          end
        default: begin ea_a[k] = la;             ea_b[k] = lb;             end
      endcase
      case (k)
        0:       begin eb_a[k] = 8'h00;    eb_b[k] = 8'h00;    end
        1:       begin eb_a[k] = 8'hFF;    eb_b[k] = 8'hFF;    end
        2:       begin eb_a[k] = 8'h01;    eb_b[k] = 8'hFF;    end
        3:       begin eb_a[k] = 8'hFF;    eb_b[k] = 8'h01;    end
        default: begin eb_a[k] = la[7:0];  eb_b[k] = lb[7:0];  end
      endcase
    end
  end

  // ---------------- responder + per-cycle compare, instance A ----------------
  int          a_tx;
  int          a_wait;
  bit          a_have, a_op_go, a_res_go, a_stuck;
  logic [7:0]  a_fault;
  logic [63:0] a_prod;
  logic [63:0] a_seen [NTX];

  initial begin
    a_op_ready = 1'b0; a_res_valid = 1'b0; a_res_data = '0;
    a_tx = 0; a_wait = 0; a_have = 0; a_op_go = 0; a_res_go = 0;
    a_stuck = 0; a_fault = '0; a_prod = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        a_op_ready = 1'b0; a_res_valid = 1'b0;
        a_have = 0; a_op_go = 0; a_res_go = 0; a_tx = 0;
      end else begin
        check("a_busy_vs_handshake", a_busy, a_op_valid | a_res_ready);
        check("a_valid_ready_excl", a_op_valid & a_res_ready, 1'b0);
        check("a_done_busy_excl", a_done & a_busy, 1'b0);
        if (a_op_valid) begin
          if (a_tx < NTX) begin
            check("a_issue_op_a", a_op_a, ea_a[a_tx]);
            check("a_issue_op_b", a_op_b, ea_b[a_tx]);
          end else check("a_issue_beyond_run", a_tx, NTX - 1);
        end
        if (a_res_ready && a_tx > 0 && a_tx <= NTX) begin
          check("a_hold_op_a", a_op_a, ea_a[a_tx-1]);
          check("a_hold_op_b", a_op_b, ea_b[a_tx-1]);
        end
        if (a_res_go) begin a_res_valid = 1'b0; a_have = 0; a_res_go = 0; end
        if (a_op_go)  begin a_have = 1; a_op_go = 0; end
        a_op_ready = !a_stuck && !a_have && ($urandom_range(0, 3) != 0);
        if (a_op_valid && a_op_ready) begin
          a_op_go = 1;
          a_prod  = mul_u32(a_op_a, a_op_b);
          if (a_tx < NTX) begin
            a_seen[a_tx] = a_prod;
            if (a_fault[a_tx]) a_prod = a_prod ^ 64'd1;
          end
          a_wait = $urandom_range(0, 3);
          a_tx++;
        end
        if (a_have) begin
          if (a_wait == 0) begin
            a_res_valid = 1'b1;
            a_res_data  = a_prod;
          end else begin
            a_wait--;
            a_res_valid = 1'b0;
          end
        end else begin
          a_res_valid = ($urandom_range(0, 4) == 0);
          a_res_data  = {$urandom, $urandom};
        end
        if (a_res_valid && a_res_ready) a_res_go = 1;
      end
    end
  end

  // ---------------- responder + per-cycle compare, instance B ----------------
  int          b_n;
  logic [15:0] b_seen [NTX];

  initial begin
    b_op_ready = 1'b1; b_res_valid = 1'b0; b_res_data = '0; b_n = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        b_res_valid = 1'b0; b_n = 0;
      end else begin
        if (b_op_valid && b_n < NTX) begin
          check("b_issue_op_a", b_op_a, eb_a[b_n]);
          check("b_issue_op_b", b_op_b, eb_b[b_n]);
        end
        if (b_res_ready) begin
          b_res_valid = 1'b1;
          b_res_data  = mul_s8(b_op_a, b_op_b);
          if (b_n < NTX) b_seen[b_n] = b_res_data;
          b_n++;
        end else b_res_valid = 1'b0;
      end
    end
  end

  // ---------------- sequences ----------------
  task automatic run_a(input string tag, input logic [15:0] exp_err,
                       input logic [15:0] exp_first, input bit poke);
    int cyc;
    @(negedge clk);
    a_tx    = 0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    cyc = 0;
    while (!a_done && cyc < 600) begin
      @(negedge clk);
      cyc++;
      start_a = poke && (cyc == 4 || cyc == 9);
    end
    start_a = 1'b0;
    check({tag, "_done"},      a_done, 1'b1);
    check({tag, "_busy"},      a_busy, 1'b0);
    check({tag, "_err_cnt"},   a_err_cnt, exp_err);
    check({tag, "_first_err"}, a_first_err, exp_first);
    check({tag, "_timeout"},   a_timeout, 1'b0);
    check({tag, "_tx_count"},  a_tx, NTX);
  endtask

  task automatic check_a_zero(input string tag);
    check({tag, "_op_a"},      a_op_a, 32'd0);
    check({tag, "_op_b"},      a_op_b, 32'd0);
    check({tag, "_op_valid"},  a_op_valid, 1'b0);
    check({tag, "_res_ready"}, a_res_ready, 1'b0);
    check({tag, "_busy"},      a_busy, 1'b0);
    check({tag, "_done"},      a_done, 1'b0);
    check({tag, "_err_cnt"},   a_err_cnt, 16'd0);
    check({tag, "_first_err"}, a_first_err, 16'd0);
    check({tag, "_timeout"},   a_timeout, 1'b0);
  endtask

  initial begin
    int cyc;
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
    repeat (3) @(negedge clk);
    check_a_zero("reset");
    check("reset_b_done", b_done, 1'b0);
    rst = 1'b1;

    run_a("golden", 16'd0, 16'd0, 1'b0);
    check("tx1_product", a_seen[1], 64'hFFFF_FFFE_0000_0001);
    check("tx2_product", a_seen[2], 64'h0000_0000_FFFF_FFFF);
    check("tx3_product", a_seen[3], 64'h0000_0000_FFFF_FFFF);

    a_fault = 8'b0010_0000;
    run_a("fault_tx5", 16'd1, 16'd5, 1'b0);
    a_fault = 8'b0100_0100;
    run_a("fault_tx2_tx6", 16'd2, 16'd2, 1'b0);
    a_fault = '0;
    run_a("restart_clears", 16'd0, 16'd0, 1'b1);

    // reset in the middle of tx 3's product wait, with an error already logged
    a_fault = 8'b0000_0010;
    @(negedge clk);
    a_tx = 0; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    cyc = 0;
    while (!(a_tx == 4 && a_res_ready) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("midrun_reached_tx3", (a_tx == 4) && a_res_ready, 1'b1);
    check("midrun_err_logged", a_err_cnt, 16'd1);
    #2 rst = 1'b0;
    #1 check_a_zero("async_reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    a_fault = '0;
    run_a("after_reset", 16'd0, 16'd0, 1'b0);

    // operand handshake never completes
    a_stuck = 1;
    @(negedge clk);
    a_tx = 0; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    cyc = 0;
    while (!a_done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("tmo_cycles", cyc, 16);
    check("tmo_flag", a_timeout, 1'b1);
    check("tmo_done", a_done, 1'b1);
    check("tmo_op_valid", a_op_valid, 1'b0);
    check("tmo_res_ready", a_res_ready, 1'b0);
    check("tmo_busy", a_busy, 1'b0);
    a_stuck = 0;
    run_a("after_timeout", 16'd0, 16'd0, 1'b0);

    // signed 8-bit instance
    @(negedge clk);
    b_n = 0; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    cyc = 0;
    while (!b_done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("s8_done", b_done, 1'b1);
    check("s8_err_cnt", b_err_cnt, 16'd0);
    check("s8_timeout", b_timeout, 1'b0);
    check("s8_tx_count", b_n, NTX);
    check("s8_tx1_product", b_seen[1], 16'h0001);
    check("s8_tx2_product", b_seen[2], 16'hFFFF);
    check("s8_tx3_product", b_seen[3], 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
